// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin sharing of one fixed-latency, single-port
// instruction memory between two core fetch stages, with per-core flush.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   req0/1, addr0/1      fetch request and word-aligned byte address per core
//   flush0/1             discard the core's in-flight fetch
//   valid0/1, rdata0/1   registered one-cycle response pulse and held data word
//   stall0/1             combinational req & ~valid
//   mem_en, mem_addr     combinational memory read strobe and address
//   mem_rdata            read word, valid MEM_LAT cycles after mem_en
module imem_arbiter #(
    parameter int unsigned W_CPU   = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [W_CPU-1:0] addr0,
    input  logic [W_CPU-1:0] addr1,
    input  logic             flush0,
    input  logic             flush1,
    output logic             valid0,
    output logic             valid1,
    output logic [W_CPU-1:0] rdata0,
    output logic [W_CPU-1:0] rdata1,
    output logic             stall0,
    output logic             stall1,
    output logic             mem_en,
    output logic [W_CPU-1:0] mem_addr,
    input  logic [W_CPU-1:0] mem_rdata
);

    // One in-flight read: occupied, owning core, discarded by a flush.
    typedef struct packed {
        logic vld;
        logic id;
        logic kill;
    } slot_t;

    logic                     prio;
    logic [1:0]               pending;
    logic [1:0]               pending_n;
    logic [1:0]               req;
    logic [1:0]               flush;
    logic [1:0]               elig;
    logic                     grant;
    logic                     gnt_id;
    slot_t [MEM_LAT-1:0]      slots;
    slot_t [MEM_LAT-1:0]      slots_k;
    slot_t [MEM_LAT-1:0]      slots_n;
    slot_t                    slot_new;
    slot_t                    tail;
    logic                     retire;

    assign req   = {req1, req0};
    assign flush = {flush1, flush0};

    // Issue: eligible cores, tie broken by prio.
    assign elig     = req & ~pending & ~flush & {2{~rst}};
    assign grant    = |elig;
    assign gnt_id   = (&elig) ? prio : elig[1];
    assign mem_en   = grant;
    assign mem_addr = grant ? (gnt_id ? addr1 : addr0) : '0;

    assign stall0 = req0 & ~valid0 & ~rst;
    assign stall1 = req1 & ~valid1 & ~rst;

    // A flush kills every in-flight slot of that core, including one retiring now.
    for (genvar i = 0; i < MEM_LAT; i++) begin : g_kill
        assign slots_k[i] = {slots[i].vld, slots[i].id,
                             slots[i].kill | (slots[i].vld & flush[slots[i].id])};
    end

    assign slot_new = {grant, gnt_id, 1'b0};

    // Age pipeline: entry at index MEM_LAT-1 lines up with mem_rdata.
    if (MEM_LAT == 1) begin : g_shift1
        assign slots_n[0] = slot_new;
    end else begin : g_shiftn
        assign slots_n = {slots_k[MEM_LAT-2:0], slot_new};
    end

    assign tail   = slots_k[MEM_LAT-1];
    assign retire = tail.vld & ~tail.kill;

    // Pending clears after the valid cycle or on flush; set by a grant.
    always_comb begin
        pending_n = pending & ~{valid1, valid0} & ~flush;
        if (grant) begin
            pending_n[gnt_id] = 1'b1;
        end
    end

    // Arbitration state and slot pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio    <= 1'b0;
            pending <= 2'b00;
            slots   <= '0;
        end else begin
            pending <= pending_n;
            slots   <= slots_n;
            if (grant) begin
                prio <= ~gnt_id;
            end
        end
    end

    // Response registers: one-cycle valid pulse, data held between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid0 <= 1'b0;
            valid1 <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            valid0 <= retire & ~tail.id;
            valid1 <= retire & tail.id;
            if (retire && !tail.id) begin
                rdata0 <= mem_rdata;
            end
            if (retire && tail.id) begin
                rdata1 <= mem_rdata;
            end
        end
    end

endmodule
